spi_shift_engine: RTL and testbench

Parametrised full-duplex shift engine: the next-generation datapath for the SPI controller, superseding the fixed 8-bit shift register. It loads a transmit word through a valid/ready handshake and shifts out a programmable number of bits, MSB- or LSB-first, while capturing the same number of bits from the serial input. Bit timing comes from separate sample and shift strobes driven by the SPI clock generator, so every SPI mode is served by one engine.

---
 rtl/spi_shift_engine.sv | 109 ++++++++++
 tb/tb_spi_shift_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: loads a word by valid/ready, then shifts out
// and captures a programmable number of bits under external sample/shift strobes.
module spi_shift_engine #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load_valid,
   output logic             o_load_ready,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic [CNT_W-1:0] i_len,
   input  logic             i_lsb_first,
   input  logic             i_sample_stb,
   input  logic             i_shift_stb,
   input  logic             i_abort,
   input  logic             i_serial,
   output logic             o_serial,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_rx_data
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic {PH_SAMPLE, PH_SHIFT} phase_t;

   state_t           state;
   state_t           state_n;
   phase_t           phase;
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-1:0] rx_sr;
   logic [WIDTH-1:0] rx_next;
   logic [WIDTH-1:0] rx_data;
   logic [CNT_W-1:0] len_r;
   logic [CNT_W-1:0] len_eff;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc;
   logic             lsb_r;
   logic             accept;
   logic             do_sample;
   logic             do_shift;
   logic             last;

   // Zero or oversize lengths mean a full-width transfer
   assign len_eff = (i_len == '0 || i_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : i_len;

   assign o_load_ready = (state == IDLE) && !i_abort && !i_rst;
   assign accept       = i_load_valid && o_load_ready;
   assign count_inc    = count + CNT_W'(1);
   assign do_sample    = (state == SHIFT) && !i_abort && (phase == PH_SAMPLE) && i_sample_stb;
   assign do_shift     = (state == SHIFT) && !i_abort && (phase == PH_SHIFT) && i_shift_stb;
   assign last         = do_sample && (count_inc == len_r);

   // MSB-first fills from bit 0 upward by shifting; LSB-first drops the bit at its index
   assign rx_next = lsb_r ? (rx_sr | (WIDTH'(i_serial) << count))
                          : {rx_sr[WIDTH-2:0], i_serial};

   assign o_busy    = (state == SHIFT);
   assign o_done    = (state == DONE);
   assign o_serial  = (state == SHIFT) && (lsb_r ? tx_sr[0] : tx_sr[WIDTH-1]);
   assign o_rx_data = rx_data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = SHIFT;
         SHIFT: begin
            if (i_abort)   state_n = IDLE;
            else if (last) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // MSB-first words are left-justified on load so the first bit sits at the top
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tx_sr   <= '0;
         rx_sr   <= '0;
         rx_data <= '0;
         len_r   <= '0;
         count   <= '0;
         lsb_r   <= 1'b0;
         phase   <= PH_SAMPLE;
      end else if (accept) begin
         tx_sr <= i_lsb_first ? i_load_data : (i_load_data << (CNT_W'(WIDTH) - len_eff));
         rx_sr <= '0;
         len_r <= len_eff;
         count <= '0;
         lsb_r <= i_lsb_first;
         phase <= PH_SAMPLE;
      end else if (do_sample) begin
         rx_sr <= rx_next;
         count <= count_inc;
         phase <= PH_SHIFT;
         if (last) rx_data <= rx_next;
      end else if (do_shift) begin
         tx_sr <= lsb_r ? (tx_sr >> 1) : (tx_sr << 1);
         phase <= PH_SAMPLE;
      end
   end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: an 8-bit instance for most scenarios
// and a 16-bit instance for full-width loopback transfers.
`timescale 1ns/1ps
module tb_spi_shift_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       lv8, rdy8, lsb8, smp8, shf8, abt8, sin8, ser8, busy8, done8;
   logic [7:0] data8, rx8;
   logic [3:0] len8;

   logic        lv16, rdy16, lsb16, smp16, shf16, abt16, sin16, ser16, busy16, done16;
   logic [15:0] data16, rx16;
   logic [4:0]  len16;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] model_rx8;

   spi_shift_engine #(.WIDTH(8)) dut8 (
      .i_clk(clk), .i_rst(rst), .i_load_valid(lv8), .o_load_ready(rdy8),
      .i_load_data(data8), .i_len(len8), .i_lsb_first(lsb8),
      .i_sample_stb(smp8), .i_shift_stb(shf8), .i_abort(abt8),
      .i_serial(sin8), .o_serial(ser8), .o_busy(busy8), .o_done(done8),
      .o_rx_data(rx8)
   );

   spi_shift_engine #(.WIDTH(16)) dut16 (
      .i_clk(clk), .i_rst(rst), .i_load_valid(lv16), .o_load_ready(rdy16),
      .i_load_data(data16), .i_len(len16), .i_lsb_first(lsb16),
      .i_sample_stb(smp16), .i_shift_stb(shf16), .i_abort(abt16),
      .i_serial(sin16), .o_serial(ser16), .o_busy(busy16), .o_done(done16),
      .o_rx_data(rx16)
   );

   // Bit i of an n-bit word in wire order
   function automatic logic seq_bit(input logic [15:0] w, input int n, input logic lsb, input int i);
      int k;
      k = lsb ? i : n - 1 - i;
      return w[k[3:0]];
   endfunction

   // One 8-bit transfer; mode 0 alternating, 1 random strobes, 2 scripted strobe abuse.
   // abort_at > 0 aborts once that many samples have been taken.
   task automatic xfer8(input logic [7:0] data, input logic [3:0] len, input logic lsb,
                        input logic [7:0] rxword, input int mode, input int abort_at,
                        input string name);
      int L, samples, shifts, cyc;
      logic [15:0] m;
      logic [7:0] exp_rx;
      logic smp, shf, eb;
      L = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
      m = 16'((32'd1 << L) - 1);
      exp_rx = rxword & m[7:0];

      n_checks++;
      if (rdy8 !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_before_load: got %b want 1", name, rdy8);
      end
      lv8 = 1'b1; data8 = data; len8 = len; lsb8 = lsb;
      smp8 = (mode == 1) ? 1'($urandom) : 1'b0;
      shf8 = (mode == 1) ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      lv8 = 1'b0; data8 = 8'($urandom); len8 = 4'($urandom); lsb8 = 1'($urandom);

      samples = 0; shifts = 0;
      for (cyc = 0; cyc < 300 && samples < L; cyc++) begin
         eb = seq_bit({8'h00, data}, L, lsb, shifts);
         n_checks++;
         if ({busy8, done8, ser8, rx8} !== {1'b1, 1'b0, eb, model_rx8}) begin
            n_fail++;
            $display("FAIL %s shift_cycle%0d: busy/done/ser/rx got %b/%b/%b/%h want 1/0/%b/%h",
                     name, cyc, busy8, done8, ser8, rx8, eb, model_rx8);
         end
         if (abort_at > 0 && samples == abort_at) begin
            abt8 = 1'b1; smp8 = 1'($urandom); shf8 = 1'($urandom);
            @(posedge clk); #1;
            abt8 = 1'b0; smp8 = 1'b0; shf8 = 1'b0;
            #0;
            n_checks++;
            if ({busy8, done8, ser8, rdy8, rx8} !== {1'b0, 1'b0, 1'b0, 1'b1, model_rx8}) begin
               n_fail++;
               $display("FAIL %s after_abort: busy/done/ser/ready/rx got %b/%b/%b/%b/%h want 0/0/0/1/%h",
                        name, busy8, done8, ser8, rdy8, rx8, model_rx8);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({done8, busy8, rx8} !== {1'b0, 1'b0, model_rx8}) begin
               n_fail++;
               $display("FAIL %s abort_no_done: done/busy/rx got %b/%b/%h want 0/0/%h",
                        name, done8, busy8, rx8, model_rx8);
            end
            return;
         end
         case (mode)
            0: begin smp = (samples == shifts); shf = (samples != shifts); end
            1: begin smp = 1'($urandom); shf = 1'($urandom); end
            default: begin
               smp = (cyc != 0);
               shf = (cyc == 0) || (cyc > 2);
            end
         endcase
         smp8 = smp; shf8 = shf;
         sin8 = seq_bit({8'h00, rxword}, L, lsb, samples);
         if (smp && samples == shifts)     samples++;
         else if (shf && shifts < samples) shifts++;
         @(posedge clk); #1;
      end
      smp8 = 1'b0; shf8 = 1'b0;

      n_checks++;
      if (samples < L) begin
         n_fail++;
         $display("FAIL %s timeout: samples got %0d want %0d", name, samples, L);
         return;
      end
      model_rx8 = exp_rx;
      n_checks++;
      if ({done8, busy8, ser8, rdy8, rx8} !== {1'b1, 1'b0, 1'b0, 1'b0, exp_rx}) begin
         n_fail++;
         $display("FAIL %s done_cycle: done/busy/ser/ready/rx got %b/%b/%b/%b/%h want 1/0/0/0/%h",
                  name, done8, busy8, ser8, rdy8, rx8, exp_rx);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({done8, busy8, rdy8, rx8} !== {1'b0, 1'b0, 1'b1, exp_rx}) begin
         n_fail++;
         $display("FAIL %s after_done: done/busy/ready/rx got %b/%b/%b/%h want 0/0/1/%h",
                  name, done8, busy8, rdy8, rx8, exp_rx);
      end
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if ({ser8, busy8, done8, rdy8, rx8, ser16, busy16, done16, rdy16, rx16} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: ser/busy/done/ready/rx got %b/%b/%b/%b/%h want all 0",
                  ser8, busy8, done8, rdy8, rx8);
      end
      @(negedge clk); rst = 1'b0; #1;
      n_checks++;
      if ({rdy8, busy8, rx8, rdy16, busy16} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_release: ready/busy/rx got %b/%b/%h want 1/0/00", rdy8, busy8, rx8);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_msb_first();
      xfer8(8'hA5, 4'd8, 1'b0, 8'h3C, 0, 0, "msb_first");
   endtask

   task automatic test_abort();
      xfer8(8'h96, 4'd8, 1'b0, 8'hE1, 0, 3, "abort_mid");
      lv8 = 1'b1; abt8 = 1'b1; data8 = 8'h5A; len8 = 4'd8;
      #0;
      n_checks++;
      if (rdy8 !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle_ready: got %b want 0", rdy8);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({busy8, done8} !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_idle_load: busy/done got %b/%b want 0/0", busy8, done8);
      end
      lv8 = 1'b0; abt8 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_lsb_first();
      xfer8(8'h16, 4'd5, 1'b1, 8'h13, 0, 0, "lsb_first");
   endtask

   task automatic test_strobe_discipline();
      xfer8(8'($urandom), 4'd8, 1'b0, 8'($urandom), 2, 0, "strobe_msb");
      xfer8(8'($urandom), 4'd8, 1'b1, 8'($urandom), 2, 0, "strobe_lsb");
   endtask

   task automatic test_random();
      for (int t = 0; t < 12; t++)
         xfer8(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 8'($urandom), 1, 0, "random");
   endtask

   task automatic test_mid_reset();
      lv8 = 1'b1; data8 = 8'hC3; len8 = 4'd8; lsb8 = 1'b0;
      @(posedge clk); #1;
      lv8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         smp8 = (i % 2 == 0); shf8 = (i % 2 == 1); sin8 = 1'($urandom);
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      model_rx8 = 8'h00;
      n_checks++;
      if ({ser8, busy8, done8, rdy8, rx8, rx16} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: ser/busy/done/ready/rx got %b/%b/%b/%b/%h want all 0",
                  ser8, busy8, done8, rdy8, rx8);
      end
      smp8 = 1'b0; shf8 = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({rdy8, busy8, done8, rx8} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL mid_reset_release: ready/busy/done/rx got %b/%b/%b/%h want 1/0/0/00",
                  rdy8, busy8, done8, rx8);
      end
      @(posedge clk); #1;
   endtask

   // 16-bit full-width transfer with o_serial looped to i_serial
   task automatic xfer16_loop(input logic lsb);
      int samples, shifts, edges;
      logic eb;
      lv16 = 1'b1; data16 = 16'hBEEF; len16 = 5'd0; lsb16 = lsb;
      @(posedge clk); #1;
      lv16 = 1'b0; data16 = 16'h0000;
      samples = 0; shifts = 0; edges = 0;
      while (samples < 16 && edges < 100) begin
         eb = seq_bit(16'hBEEF, 16, lsb, shifts);
         n_checks++;
         if ({busy16, ser16} !== {1'b1, eb}) begin
            n_fail++;
            $display("FAIL wide_lsb%0b bit%0d: busy/ser got %b/%b want 1/%b", lsb, shifts, busy16, ser16, eb);
         end
         sin16 = ser16;
         smp16 = (samples == shifts); shf16 = (samples != shifts);
         if (samples == shifts) samples++; else shifts++;
         @(posedge clk); #1;
         edges++;
      end
      smp16 = 1'b0; shf16 = 1'b0;
      n_checks++;
      if ({done16, rx16} !== {1'b1, 16'hBEEF} || edges != 31) begin
         n_fail++;
         $display("FAIL wide_lsb%0b result: done/rx/cycles got %b/%h/%0d want 1/beef/31",
                  lsb, done16, rx16, edges);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({done16, rdy16, rx16} !== {1'b0, 1'b1, 16'hBEEF}) begin
         n_fail++;
         $display("FAIL wide_lsb%0b after_done: done/ready/rx got %b/%b/%h want 0/1/beef",
                  lsb, done16, rdy16, rx16);
      end
   endtask

   task automatic test_wide_loopback();
      xfer16_loop(1'b0);
      xfer16_loop(1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; model_rx8 = 8'h00;
      lv8 = 1'b0; data8 = '0; len8 = '0; lsb8 = 1'b0; smp8 = 1'b0; shf8 = 1'b0; abt8 = 1'b0; sin8 = 1'b0;
      lv16 = 1'b0; data16 = '0; len16 = '0; lsb16 = 1'b0; smp16 = 1'b0; shf16 = 1'b0; abt16 = 1'b0; sin16 = 1'b0;
      test_reset();
      test_msb_first();
      test_abort();
      test_lsb_first();
      test_strobe_discipline();
      test_random();
      test_mid_reset();
      test_wide_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
